// File: rtl/signed_nibble_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signed_nibble_pkg
// Description : Shared types and helpers for the signed nibble accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package signed_nibble_pkg;

    // Widest accumulator sext8 can feed; callers slice the low ACC_W bits.
    localparam int c_SEXT_W = 64;

    typedef struct packed signed {
        bit [3:0] lo;
        bit [3:0] hi;
    } nib_pair_t;

    typedef enum logic [1:0] {
        LO  = 2'd0,
        HI  = 2'd1,
        OUT = 2'd2
    } state_t;

    function automatic logic signed [c_SEXT_W-1:0] sext8(input nib_pair_t b);
        return {{(c_SEXT_W-8){b.lo[3]}}, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/signed_nibble_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_nibble_accum_if
// Description : Nibble input and frame-result handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_nibble_accum_if #(
    parameter int ACC_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_nibble;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_nibble, out_ready,
        input  in_ready, out_valid, out_byte, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_nibble, out_ready,
        output in_ready, out_valid, out_byte, out_sum, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/signed_nibble_accum_nibble_pair_assembler.sv
`default_nettype none
// ============================================================================
// Module      : nibble_pair_assembler
// Description : Pairs consecutive accepted nibbles into a packed signed byte.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_pair_assembler
    import signed_nibble_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       nib_valid,
    input  wire logic [3:0] nibble,
    output nib_pair_t       pair,
    output logic            pair_valid
);

    logic [3:0] r_lo;
    logic       r_phase_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo       <= 4'h0;
            r_phase_hi <= 1'b0;
        end else if (nib_valid) begin
            r_phase_hi <= ~r_phase_hi;
            if (!r_phase_hi) begin
                r_lo <= nibble;
            end
        end
    end

    // The hi nibble is used straight off the input so the byte lands in the
    // accumulator on the same edge that accepts it.
    always_comb begin
        pair.lo = r_lo;
        pair.hi = nibble;
    end

    assign pair_valid = nib_valid & r_phase_hi;

endmodule
`default_nettype wire

// File: rtl/signed_nibble_accum.sv
`default_nettype none
// ============================================================================
// Module      : signed_nibble_accum
// Description : Accumulates COUNT sign-extended nibble-pair bytes per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_nibble_accum
    import signed_nibble_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    signed_nibble_accum_if.slave bus
);

    localparam logic [7:0] c_LAST = 8'(COUNT - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [7:0]                r_cnt;
    logic [7:0]                r_byte;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_ovf;

    logic                      w_in_hs;
    logic                      w_out_hs;
    logic                      w_last;
    nib_pair_t                 w_pair;
    logic                      w_pair_valid;
    logic signed [c_SEXT_W-1:0] w_ext_full;
    logic signed [ACC_W-1:0]   w_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_ovf_step;

    assign w_in_hs = bus.in_valid & r_in_ready;
    assign w_last  = (r_cnt == c_LAST);

    nibble_pair_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .nib_valid  (w_in_hs),
        .nibble     (bus.in_nibble),
        .pair       (w_pair),
        .pair_valid (w_pair_valid)
    );

    assign w_ext_full = sext8(w_pair);
    assign w_ext      = w_ext_full[ACC_W-1:0];

    generate
        if (ACC_W < c_SEXT_W) begin : g_ext_unused
            logic w_unused_ext_hi;
            assign w_unused_ext_hi = ^w_ext_full[c_SEXT_W-1:ACC_W];
        end
    endgenerate

    assign w_sum      = r_acc + w_ext;
    assign w_ovf_step = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_hs    = 1'b0;
        case (r_state)
            LO: begin
                if (w_in_hs) begin
                    w_state_nxt = HI;
                end
            end
            HI: begin
                if (w_in_hs) begin
                    w_state_nxt = w_last ? OUT : LO;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    w_out_hs    = 1'b1;
                    w_state_nxt = LO;
                end
            end
            default: w_state_nxt = LO;
        endcase
    end

    // Handshake flags are registered from the next state so every output
    // comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= 8'd0;
            r_byte      <= 8'h00;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt != OUT);
            r_out_valid <= (w_state_nxt == OUT);
            if (w_pair_valid) begin
                r_acc  <= w_sum;
                r_ovf  <= r_ovf | w_ovf_step;
                r_byte <= w_pair;
                r_cnt  <= r_cnt + 8'd1;
            end else if (w_out_hs) begin
                r_acc  <= '0;
                r_ovf  <= 1'b0;
                r_cnt  <= 8'd0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_byte  = r_byte;
    assign bus.out_sum   = r_acc;
    assign bus.out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_signed_nibble_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_nibble_accum
// Description : Self-checking bench for signed_nibble_accum (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_nibble_accum;

    logic       clk;
    logic       rst;
    int         sel;
    logic       drv_valid;
    logic [3:0] drv_nib;
    logic       drv_ordy;

    int n_chk  = 0;
    int n_fail = 0;

    signed_nibble_accum_if #(.ACC_W(16)) if1 ();
    signed_nibble_accum_if #(.ACC_W(16)) if4 ();
    signed_nibble_accum_if #(.ACC_W(8))  if8 ();

    assign if1.in_valid  = (sel == 0) & drv_valid;
    assign if4.in_valid  = (sel == 1) & drv_valid;
    assign if8.in_valid  = (sel == 2) & drv_valid;
    assign if1.in_nibble = drv_nib;
    assign if4.in_nibble = drv_nib;
    assign if8.in_nibble = drv_nib;
    assign if1.out_ready = (sel == 0) & drv_ordy;
    assign if4.out_ready = (sel == 1) & drv_ordy;
    assign if8.out_ready = (sel == 2) & drv_ordy;

    signed_nibble_accum #(.COUNT(1), .ACC_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    signed_nibble_accum #(.COUNT(4), .ACC_W(16)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    signed_nibble_accum #(.COUNT(2), .ACC_W(8))  dut8 (.clk(clk), .rst(rst), .bus(if8));

    logic        m_in_ready;
    logic        m_out_valid;
    logic [7:0]  m_byte;
    logic [15:0] m_sum;
    logic        m_ovf;

    always_comb begin
        m_in_ready  = 1'b0;
        m_out_valid = 1'b0;
        m_byte      = 8'h00;
        m_sum       = 16'h0000;
        m_ovf       = 1'b0;
        case (sel)
            0: begin
                m_in_ready = if1.in_ready; m_out_valid = if1.out_valid;
                m_byte = if1.out_byte; m_sum = if1.out_sum; m_ovf = if1.out_ovf;
            end
            1: begin
                m_in_ready = if4.in_ready; m_out_valid = if4.out_valid;
                m_byte = if4.out_byte; m_sum = if4.out_sum; m_ovf = if4.out_ovf;
            end
            default: begin
                m_in_ready = if8.in_ready; m_out_valid = if8.out_valid;
                m_byte = if8.out_byte; m_sum = {8'h00, if8.out_sum}; m_ovf = if8.out_ovf;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [1:0]  s;
        logic [31:0] b;
        logic [2:0]  n;
        logic [15:0] sum;
        logic        ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Exact-integer reference: overflow is any partial sum outside the
    // representable range, result is wrapped modulo 2^w.
    function automatic void model(input logic [31:0] b, input int n, input int w,
                                  output logic [15:0] sum, output logic ovf);
        longint acc, s, m;
        logic [7:0] by;
        acc = 0;
        m   = longint'(1) << w;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            by = b[31-8*i -: 8];
            s  = acc + longint'($signed(by));
            if (s >= m/2 || s < -(m/2)) ovf = 1'b1;
            s = s & (m - 1);
            if (s >= m/2) s = s - m;
            acc = s;
        end
        sum = 16'(acc & (m - 1));
    endfunction

    task automatic send_nib(input logic [3:0] nib);
        int g;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_nib   = nib;
        g = 0;
        while (!m_in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: actual=0 required=1");
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
    endtask

    task automatic run_frame(input int s, input logic [31:0] b, input int n,
                             input logic [15:0] es, input logic eo, input bit gaps, input int tag);
        logic [7:0] by;
        logic [7:0] last;
        int stall;
        sel  = s;
        last = 8'h00;
        for (int i = 0; i < n; i++) begin
            by   = b[31-8*i -: 8];
            last = by;
            send_nib(by[7:4]);
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            send_nib(by[3:0]);
            if (gaps && i != n - 1) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        chk($sformatf("out_valid_latency[%0d]", tag), m_out_valid, 1);
        chk($sformatf("in_ready_in_out[%0d]", tag), m_in_ready, 0);
        chk($sformatf("out_sum[%0d]", tag), m_sum, es);
        chk($sformatf("out_byte[%0d]", tag), m_byte, last);
        chk($sformatf("out_ovf[%0d]", tag), m_ovf, eo);
        stall = gaps ? $urandom_range(0, 3) : 0;
        repeat (stall) begin
            @(negedge clk);
            drv_valid = 1'($urandom_range(0, 1));
            drv_nib   = 4'($urandom_range(0, 15));
        end
        chk($sformatf("out_sum_held[%0d]", tag), m_sum, es);
        @(negedge clk);
        drv_ordy = 1'b1;
        @(posedge clk);
        #1;
        drv_ordy  = 1'b0;
        drv_valid = 1'b0;
        chk($sformatf("out_valid_drop[%0d]", tag), m_out_valid, 0);
        chk($sformatf("in_ready_return[%0d]", tag), m_in_ready, 1);
    endtask

    initial begin
        logic [15:0] es;
        logic        eo;
        logic [31:0] rb;
        int          s, n;

        tbl[0] = '{s: 2'd0, b: 32'hC8000000, n: 3'd1, sum: 16'hFFC8, ovf: 1'b0};
        tbl[1] = '{s: 2'd1, b: 32'h7F7F7F7F, n: 3'd4, sum: 16'h01FC, ovf: 1'b0};
        tbl[2] = '{s: 2'd1, b: 32'h807F01FF, n: 3'd4, sum: 16'hFFFF, ovf: 1'b0};
        tbl[3] = '{s: 2'd1, b: 32'h80808080, n: 3'd4, sum: 16'hFE00, ovf: 1'b0};
        tbl[4] = '{s: 2'd2, b: 32'h7F010000, n: 3'd2, sum: 16'h0080, ovf: 1'b1};
        tbl[5] = '{s: 2'd2, b: 32'h01010000, n: 3'd2, sum: 16'h0002, ovf: 1'b0};
        tbl[6] = '{s: 2'd2, b: 32'h80800000, n: 3'd2, sum: 16'h0000, ovf: 1'b1};
        tbl[7] = '{s: 2'd0, b: 32'h7F000000, n: 3'd1, sum: 16'h007F, ovf: 1'b0};

        sel       = 0;
        drv_valid = 1'b0;
        drv_nib   = 4'h0;
        drv_ordy  = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            chk($sformatf("rst_in_ready[%0d]", k), m_in_ready, 1);
            chk($sformatf("rst_out_valid[%0d]", k), m_out_valid, 0);
            chk($sformatf("rst_out_byte[%0d]", k), m_byte, 0);
            chk($sformatf("rst_out_sum[%0d]", k), m_sum, 0);
            chk($sformatf("rst_out_ovf[%0d]", k), m_ovf, 0);
        end

        for (int i = 0; i < 8; i++) begin
            run_frame(int'(tbl[i].s), tbl[i].b, int'(tbl[i].n), tbl[i].sum, tbl[i].ovf, 1'b0, i);
        end

        // Backpressure with the source still presenting data.
        sel = 1;
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4);
        send_nib(4'h5); send_nib(4'h6); send_nib(4'h7); send_nib(4'h8);
        drv_valid = 1'b1;
        drv_nib   = 4'hA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_out_valid[%0d]", c), m_out_valid, 1);
            chk($sformatf("bp_in_ready[%0d]", c), m_in_ready, 0);
            chk($sformatf("bp_out_sum[%0d]", c), m_sum, 16'h0114);
            chk($sformatf("bp_out_byte[%0d]", c), m_byte, 8'h78);
        end
        drv_ordy = 1'b1;
        @(posedge clk);
        #1;
        drv_ordy  = 1'b0;
        drv_valid = 1'b0;
        chk("bp_release_in_ready", m_in_ready, 1);
        chk("bp_release_out_valid", m_out_valid, 0);

        // Reset in the middle of a frame, one nibble into the second byte.
        send_nib(4'h7); send_nib(4'hF); send_nib(4'h7);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", m_in_ready, 1);
        chk("midrst_out_valid", m_out_valid, 0);
        chk("midrst_out_byte", m_byte, 0);
        chk("midrst_out_sum", m_sum, 0);
        chk("midrst_out_ovf", m_ovf, 0);
        run_frame(1, 32'h01010101, 4, 16'h0004, 1'b0, 1'b0, 50);

        for (int k = 0; k < 30; k++) begin
            s  = int'($urandom_range(0, 2));
            n  = (s == 0) ? 1 : ((s == 1) ? 4 : 2);
            rb = $urandom;
            model(rb, n, (s == 2) ? 8 : 16, es, eo);
            run_frame(s, rb, n, es, eo, 1'b1, 100 + k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
